// File: rtl/wirein_led_ctrl_pkg.sv
// Shared constants for the WireIn-driven LED controller: mode encodings and
// status-word bit positions.
package wirein_led_pkg;

    localparam logic [2:0] MODE_STATIC = 3'd0;
    localparam logic [2:0] MODE_BLINK  = 3'd1;
    localparam logic [2:0] MODE_CHASE  = 3'd2;
    localparam logic [2:0] MODE_PWM    = 3'd3;

    localparam int ST_ERR      = 15;
    localparam int ST_PHASE    = 14;
    localparam int ST_MODE_MSB = 13;
    localparam int ST_MODE_LSB = 11;

    // Modes 4..7 are reserved; all valid modes have bit 2 clear.
    function automatic logic mode_reserved(input logic [2:0] mode);
        return mode[2];
    endfunction

endpackage

// File: rtl/wirein_led_ctrl_if.sv
// Host-side WireIn/TriggerIn bundle feeding the LED controller.
interface wirein_led_ctrl_if;

    logic [15:0] ep_ctrl;
    logic [15:0] ep_pattern;
    logic [15:0] ep_rate_lo;
    logic [15:0] ep_rate_hi;
    logic        update;

    modport master (output ep_ctrl, ep_pattern, ep_rate_lo, ep_rate_hi, update);
    modport slave  (input  ep_ctrl, ep_pattern, ep_rate_lo, ep_rate_hi, update);

endinterface

// File: rtl/wirein_led_ctrl_prescaler.sv
// Rate prescaler: counts 0..rate and pulses tick on the terminal count,
// giving a tick period of rate+1 cycles; clear restarts the count at 0.
module led_prescaler #(
    parameter int RATE_BITS = 24
) (
    input  logic                 ti_clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [RATE_BITS-1:0] rate,
    output logic                 tick
);

    logic [RATE_BITS-1:0] cnt_q;
    logic [RATE_BITS-1:0] cnt_d;

    assign tick = (cnt_q == rate);

    always_comb begin
        cnt_d = cnt_q + RATE_BITS'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wirein_led_ctrl.sv
// LED controller: host WireIn words are committed atomically on a TriggerIn
// pulse and drive NUM_LEDS outputs in static, blink, chase or PWM mode.
module wirein_led_ctrl
    import wirein_led_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int RATE_BITS      = 24,
    parameter int PWM_BITS       = 8,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                ti_clk,
    input  logic                rst,
    wirein_led_ctrl_if.slave    host,
    output logic [NUM_LEDS-1:0] led,
    output logic [15:0]         status
);

    localparam logic [NUM_LEDS-1:0] LED_OFF =
        (LED_ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

    logic [2:0]           mode_q,     mode_d;
    logic [NUM_LEDS-1:0]  pattern_q,  pattern_d;
    logic [RATE_BITS-1:0] rate_q,     rate_d;
    logic [PWM_BITS-1:0]  duty_q,     duty_d;
    logic                 phase_q,    phase_d;
    logic [NUM_LEDS-1:0]  chase_q,    chase_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [7:0]           tick_cnt_q, tick_cnt_d;
    logic                 err_q,      err_d;
    logic [NUM_LEDS-1:0]  led_q,      led_d;
    logic [15:0]          status_q,   status_d;

    logic                 tick;
    logic [NUM_LEDS-1:0]  led_state;
    logic [31:0]          rate_word;
    logic                 unused_bits;

    assign rate_word   = {host.ep_rate_hi, host.ep_rate_lo};
    assign unused_bits = ^{host.ep_ctrl, host.ep_pattern, rate_word};

    led_prescaler #(.RATE_BITS(RATE_BITS)) u_prescaler (
        .ti_clk (ti_clk),
        .rst    (rst),
        .clear  (host.update),
        .rate   (rate_q),
        .tick   (tick)
    );

    // A commit takes priority over a coincident tick, so the reload is never rotated.
    always_comb begin
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        rate_d     = rate_q;
        duty_d     = duty_q;
        phase_d    = phase_q;
        chase_d    = chase_q;
        tick_cnt_d = tick_cnt_q;
        err_d      = err_q;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        if (host.update) begin
            mode_d     = host.ep_ctrl[2:0];
            pattern_d  = host.ep_pattern[NUM_LEDS-1:0];
            rate_d     = rate_word[RATE_BITS-1:0];
            duty_d     = host.ep_ctrl[8 +: PWM_BITS];
            phase_d    = 1'b0;
            chase_d    = host.ep_pattern[NUM_LEDS-1:0];
            tick_cnt_d = '0;
            err_d      = mode_reserved(host.ep_ctrl[2:0]);
        end else if (tick) begin
            phase_d    = ~phase_q;
            chase_d    = (chase_q << 1) | (chase_q >> (NUM_LEDS - 1));
            tick_cnt_d = tick_cnt_q + 8'd1;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_STATIC: led_state = pattern_q;
            MODE_BLINK:  led_state = phase_q ? pattern_q : '0;
            MODE_CHASE:  led_state = chase_q;
            MODE_PWM:    led_state = (pwm_cnt_q < duty_q) ? pattern_q : '0;
            default:     led_state = '0;
        endcase
        led_d = (LED_ACTIVE_LOW != 0) ? ~led_state : led_state;

        status_d                          = '0;
        status_d[ST_ERR]                  = err_q;
        status_d[ST_PHASE]                = phase_q;
        status_d[ST_MODE_MSB:ST_MODE_LSB] = mode_q;
        status_d[7:0]                     = tick_cnt_q;
    end

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_STATIC;
            pattern_q  <= '0;
            rate_q     <= '0;
            duty_q     <= '0;
            phase_q    <= 1'b0;
            chase_q    <= '0;
            pwm_cnt_q  <= '0;
            tick_cnt_q <= '0;
            err_q      <= 1'b0;
            led_q      <= LED_OFF;
            status_q   <= '0;
        end else begin
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            rate_q     <= rate_d;
            duty_q     <= duty_d;
            phase_q    <= phase_d;
            chase_q    <= chase_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            err_q      <= err_d;
            led_q      <= led_d;
            status_q   <= status_d;
        end
    end

    assign led    = led_q;
    assign status = status_q;

endmodule
